// File: rtl/frame_sync_ctrl.sv
// frame_sync_ctrl: 802.15.4 receive framer (preamble/SFD hunt, PHR length, PSDU byte delivery).
// Define CRC_CHECK_EN to add the CRC-16 ITU-T FCS check that drives crc_ok_o.
module frame_sync_ctrl #(
  parameter int         PREAMBLE_MIN = 24,
  parameter logic [7:0] SFD_VAL      = 8'hA7,
  parameter int         SFD_WINDOW   = 16,
  parameter int         MAX_LEN      = 127,
  parameter int         TIMEOUT      = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       bit_i,
  input  logic       bit_en_i,
  output logic       cdr_en_o,
  output logic       cdr_clr_o,
  output logic       sfd_o,
  output logic [6:0] len_o,
  output logic       len_valid_o,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_done_o,
  output logic       frame_err_o,
  output logic       crc_ok_o,
  output logic       busy_o
);

  // state   | meaning
  // IDLE    | receiver disabled, CDR stopped
  // HUNT    | counting consecutive preamble zeros
  // SFD     | looking for the delimiter inside the window
  // PHR     | collecting the length byte
  // PAYLOAD | assembling and delivering PSDU bytes
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HUNT = 3'd1;
  localparam logic [2:0] S_SFD  = 3'd2;
  localparam logic [2:0] S_PHR  = 3'd3;
  localparam logic [2:0] S_PAY  = 3'd4;

`ifdef CRC_CHECK_EN
  localparam int MIN_LEN = 2;
`else
  localparam int MIN_LEN = 1;
`endif

  logic [2:0] state_q, state_d;
  logic [4:0] zcnt_q, zcnt_d;
  logic [4:0] win_q, win_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] sh_q, sh_d;
  logic [6:0] rem_q, rem_d;
  logic [7:0] gap_q, gap_d;
  logic [6:0] len_q, len_d;
  logic [7:0] byte_q, byte_d;
  logic       cdr_clr_q, cdr_clr_d, sfd_q, sfd_d, len_valid_q, len_valid_d;
  logic       byte_valid_q, byte_valid_d, done_q, done_d, err_q, err_d;
  logic [7:0] shifted;
  logic       in_frame;

  assign shifted  = {bit_i, sh_q[7:1]};
  assign in_frame = (state_q == S_SFD) || (state_q == S_PHR) || (state_q == S_PAY);

  always_comb begin
    state_d      = state_q;
    zcnt_d       = zcnt_q;
    win_d        = win_q;
    bcnt_d       = bcnt_q;
    sh_d         = sh_q;
    rem_d        = rem_q;
    len_d        = len_q;
    byte_d       = byte_q;
    gap_d        = 8'(TIMEOUT - 1);
    cdr_clr_d    = 1'b0;
    sfd_d        = 1'b0;
    len_valid_d  = 1'b0;
    byte_valid_d = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      S_IDLE: if (enable_i) begin
        cdr_clr_d = 1'b1;
        zcnt_d    = '0;
        state_d   = S_HUNT;
      end
      S_HUNT: if (bit_en_i) begin
        if (bit_i) zcnt_d = '0;
        else if (zcnt_q != 5'(PREAMBLE_MIN)) zcnt_d = zcnt_q + 5'd1;
        if (!bit_i && (zcnt_q + 5'd1 == 5'(PREAMBLE_MIN))) begin
          sh_d    = '0;
          win_d   = '0;
          state_d = S_SFD;
        end
      end
      S_SFD: if (bit_en_i) begin
        sh_d  = shifted;
        win_d = win_q + 5'd1;
        if (shifted == SFD_VAL) begin
          sfd_d   = 1'b1;
          bcnt_d  = '0;
          state_d = S_PHR;
        end else if (win_d == 5'(SFD_WINDOW)) begin
          err_d     = 1'b1;
          cdr_clr_d = 1'b1;
          zcnt_d    = '0;
          state_d   = S_HUNT;
        end
      end
      S_PHR: if (bit_en_i) begin
        sh_d   = shifted;
        bcnt_d = bcnt_q + 3'd1;
        if (bcnt_q == 3'd7) begin
          // bit 7 of the PHR is reserved and not part of the length
          if (int'(shifted[6:0]) < MIN_LEN || int'(shifted[6:0]) > MAX_LEN) begin
            err_d     = 1'b1;
            cdr_clr_d = 1'b1;
            zcnt_d    = '0;
            state_d   = S_HUNT;
          end else begin
            len_d       = shifted[6:0];
            len_valid_d = 1'b1;
            rem_d       = shifted[6:0];
            state_d     = S_PAY;
          end
        end
      end
      S_PAY: if (bit_en_i) begin
        sh_d   = shifted;
        bcnt_d = bcnt_q + 3'd1;
        if (bcnt_q == 3'd7) begin
          byte_d       = shifted;
          byte_valid_d = 1'b1;
          rem_d        = rem_q - 7'd1;
          if (rem_q == 7'd1) begin
            done_d    = 1'b1;
            cdr_clr_d = 1'b1;
            zcnt_d    = '0;
            state_d   = S_HUNT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (in_frame && !bit_en_i) begin
      if (gap_q == '0) begin
        err_d     = 1'b1;
        cdr_clr_d = 1'b1;
        zcnt_d    = '0;
        state_d   = S_HUNT;
      end else begin
        gap_d = gap_q - 8'd1;
      end
    end

    // disable aborts everything except a frame completing on this very bit
    if (!enable_i && state_q != S_IDLE) begin
      state_d      = S_IDLE;
      err_d        = ((state_q == S_PHR) || (state_q == S_PAY)) && !done_d;
      cdr_clr_d    = done_d;
      sfd_d        = 1'b0;
      len_valid_d  = 1'b0;
      len_d        = len_q;
      byte_valid_d = done_d;
      if (!done_d) byte_d = byte_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      zcnt_q       <= '0;
      win_q        <= '0;
      bcnt_q       <= '0;
      sh_q         <= '0;
      rem_q        <= '0;
      gap_q        <= 8'(TIMEOUT - 1);
      len_q        <= '0;
      byte_q       <= '0;
      cdr_clr_q    <= 1'b0;
      sfd_q        <= 1'b0;
      len_valid_q  <= 1'b0;
      byte_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      zcnt_q       <= zcnt_d;
      win_q        <= win_d;
      bcnt_q       <= bcnt_d;
      sh_q         <= sh_d;
      rem_q        <= rem_d;
      gap_q        <= gap_d;
      len_q        <= len_d;
      byte_q       <= byte_d;
      cdr_clr_q    <= cdr_clr_d;
      sfd_q        <= sfd_d;
      len_valid_q  <= len_valid_d;
      byte_valid_q <= byte_valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

`ifdef CRC_CHECK_EN
  logic [15:0] crc_q, crc_d, crc_nxt;
  logic        crc_ok_q, crc_ok_d;

  // x^16+x^12+x^5+1, fed in bit arrival order; FCS included so a good frame leaves 0
  always_comb begin
    crc_nxt = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ bit_i) ? 16'h1021 : 16'h0000);
    crc_d   = crc_q;
    if (state_q == S_PHR) crc_d = '0;
    else if (state_q == S_PAY && bit_en_i) crc_d = crc_nxt;
    crc_ok_d = crc_ok_q;
    if (sfd_d) crc_ok_d = 1'b0;
    else if (done_d) crc_ok_d = (crc_nxt == 16'h0000);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      crc_q    <= '0;
      crc_ok_q <= 1'b0;
    end else begin
      crc_q    <= crc_d;
      crc_ok_q <= crc_ok_d;
    end
  end

  assign crc_ok_o = crc_ok_q;
`else
  assign crc_ok_o = 1'b0;
`endif

  assign cdr_en_o     = (state_q != S_IDLE);
  assign busy_o       = in_frame;
  assign cdr_clr_o    = cdr_clr_q;
  assign sfd_o        = sfd_q;
  assign len_o        = len_q;
  assign len_valid_o  = len_valid_q;
  assign byte_o       = byte_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_done_o = done_q;
  assign frame_err_o  = err_q;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// tb_frame_sync_ctrl: directed bench for frame_sync_ctrl with hand-computed expectations.
module tb_frame_sync_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       enable_i = 1'b0;
  logic       bit_i = 1'b0;
  logic       bit_en_i = 1'b0;
  logic       cdr_en_o, cdr_clr_o, sfd_o, len_valid_o, byte_valid_o;
  logic       frame_done_o, frame_err_o, crc_ok_o, busy_o;
  logic [6:0] len_o;
  logic [7:0] byte_o;

  int total = 0;
  int bad = 0;
  int n_sfd = 0, n_byte = 0, n_done = 0, n_err = 0, n_done_clr = 0;
  int b_sfd, b_byte, b_done, b_err, b_done_clr;
  logic [7:0] byte_log [0:255];

  frame_sync_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .bit_i(bit_i), .bit_en_i(bit_en_i),
    .cdr_en_o(cdr_en_o), .cdr_clr_o(cdr_clr_o), .sfd_o(sfd_o), .len_o(len_o),
    .len_valid_o(len_valid_o), .byte_o(byte_o), .byte_valid_o(byte_valid_o),
    .frame_done_o(frame_done_o), .frame_err_o(frame_err_o), .crc_ok_o(crc_ok_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (sfd_o) n_sfd++;
    if (byte_valid_o) begin
      byte_log[n_byte % 256] = byte_o;
      n_byte++;
    end
    if (frame_done_o) n_done++;
    if (frame_err_o) n_err++;
    if (frame_done_o && cdr_clr_o && byte_valid_o) n_done_clr++;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bit_i    = b;
    bit_en_i = 1'b1;
    @(posedge clk_i);
    #1;
    bit_en_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic mark();
    b_sfd      = n_sfd;
    b_byte     = n_byte;
    b_done     = n_done;
    b_err      = n_err;
    b_done_clr = n_done_clr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [15:0] pat;
    logic [7:0] t2_exp [0:1];
    t2_exp[0] = 8'hAA;
    t2_exp[1] = 8'h55;

    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check_val("rst_cdr_en", cdr_en_o, 0);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_len", len_o, 0);
    check_val("rst_byte", byte_o, 0);
    check_val("rst_pulses", {cdr_clr_o, sfd_o, len_valid_o, byte_valid_o,
                             frame_done_o, frame_err_o, crc_ok_o}, 0);

    enable_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_val("en_clr", cdr_clr_o, 1);
    check_val("en_cdr_en", cdr_en_o, 1);

    // 1: nominal frame of five bytes
    mark();
    send_zeros(32);
    send_byte(8'hA7);
    send_byte(8'h05);
    check_val("t1_len_valid", len_valid_o, 1);
    check_val("t1_len", len_o, 5);
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    check_val("t1_done", frame_done_o, 1);
    check_val("t1_done_clr", cdr_clr_o, 1);
`ifndef CRC_CHECK_EN
    check_val("t1_crc_tied0", crc_ok_o, 0);
`endif
    @(posedge clk_i);
    #1;
    check_val("t1_sfd_cnt", n_sfd - b_sfd, 1);
    check_val("t1_byte_cnt", n_byte - b_byte, 5);
    for (int i = 0; i < 5; i++) check_val("t1_byte_val", byte_log[(b_byte + i) % 256], i + 1);
    check_val("t1_done_cnt", n_done - b_done, 1);
    check_val("t1_done_with_byte_clr", n_done_clr - b_done_clr, 1);
    check_val("t1_err_cnt", n_err - b_err, 0);
    check_val("t1_hunt", busy_o, 0);
    check_val("t1_cdr_en", cdr_en_o, 1);

    // 2: a one breaks the zero run
    mark();
    send_zeros(20);
    send_bit(1'b1);
    send_zeros(4);
    check_val("t2_no_preamble", busy_o, 0);
    send_zeros(20);
    check_val("t2_preamble", busy_o, 1);
    check_val("t2_no_early_sfd", n_sfd - b_sfd, 0);
    send_byte(8'hA7);
    check_val("t2_sfd", sfd_o, 1);
    send_byte(8'h02);
    send_byte(8'hAA);
    send_byte(8'h55);
    check_val("t2_done", frame_done_o, 1);
    @(posedge clk_i);
    #1;
    check_val("t2_byte_cnt", n_byte - b_byte, 2);
    for (int i = 0; i < 2; i++) check_val("t2_byte_val", byte_log[(b_byte + i) % 256], t2_exp[i]);

    // 3: SFD window exhausted
    mark();
    pat = 16'h5555;
    send_zeros(24);
    for (int i = 0; i < 15; i++) send_bit(pat[i]);
    check_val("t3_no_early_err", n_err - b_err, 0);
    send_bit(pat[15]);
    check_val("t3_err", frame_err_o, 1);
    check_val("t3_clr", cdr_clr_o, 1);
    @(posedge clk_i);
    #1;
    check_val("t3_hunt", busy_o, 0);
    check_val("t3_sfd_cnt", n_sfd - b_sfd, 0);

    // 4: PHR length 0 rejected, 0xFF gives 127, then disable mid-payload
    send_zeros(24);
    send_byte(8'hA7);
    send_byte(8'h00);
    check_val("t4_len0_err", frame_err_o, 1);
    check_val("t4_len0_no_valid", len_valid_o, 0);
    send_zeros(24);
    send_byte(8'hA7);
    send_byte(8'hFF);
    check_val("t4_len127_valid", len_valid_o, 1);
    check_val("t4_len127", len_o, 127);
    mark();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    enable_i = 1'b0;
    @(posedge clk_i);
    #1;
    check_val("t4_abort_cdr_en", cdr_en_o, 0);
    check_val("t4_abort_err", frame_err_o, 1);
    check_val("t4_abort_busy", busy_o, 0);
    check_val("t4_abort_no_done", n_done - b_done, 0);
    enable_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_val("t4_rearm_clr", cdr_clr_o, 1);

    // 4b: length 1 is the lower boundary
    send_zeros(24);
    send_byte(8'hA7);
    send_byte(8'h01);
`ifdef CRC_CHECK_EN
    check_val("t4b_len1_err", frame_err_o, 1);
    check_val("t4b_len1_no_valid", len_valid_o, 0);
`else
    check_val("t4b_len1_valid", len_valid_o, 1);
    check_val("t4b_len1", len_o, 1);
    send_byte(8'h3C);
    check_val("t4b_done", frame_done_o, 1);
    check_val("t4b_byte", byte_o, 8'h3C);
`endif

    // 5: strobes stop during payload byte 2
    send_zeros(24);
    send_byte(8'hA7);
    send_byte(8'h03);
    send_byte(8'h11);
    mark();
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    k = 0;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk_i);
      #1;
      if (frame_err_o && k == 0) k = c;
    end
    check_val("t5_timeout_cycles", k, 255);
    check_val("t5_no_done", n_done - b_done, 0);
    check_val("t5_err_cnt", n_err - b_err, 1);
    check_val("t5_hunt", busy_o, 0);

`ifdef CRC_CHECK_EN
    // 6: payload 0x41 with FCS 8D 53, then the same frame with one payload bit flipped
    send_zeros(24);
    send_byte(8'hA7);
    send_byte(8'h03);
    send_byte(8'h41);
    send_byte(8'h8D);
    send_byte(8'h53);
    check_val("t6_done", frame_done_o, 1);
    check_val("t6_crc_ok", crc_ok_o, 1);
    send_zeros(24);
    send_byte(8'hA7);
    check_val("t6_crc_clear_on_sfd", crc_ok_o, 0);
    send_byte(8'h03);
    send_byte(8'h40);
    send_byte(8'h8D);
    send_byte(8'h53);
    check_val("t6_bad_done", frame_done_o, 1);
    check_val("t6_bad_crc", crc_ok_o, 0);
`endif

    // 7: reset wins over a coincident strobe
    send_zeros(24);
    send_byte(8'hA7);
    send_byte(8'h03);
    send_byte(8'h77);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    rst_i    = 1'b1;
    bit_i    = 1'b1;
    bit_en_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i    = 1'b0;
    bit_en_i = 1'b0;
    check_val("t7_busy", busy_o, 0);
    check_val("t7_cdr_en", cdr_en_o, 0);
    check_val("t7_len", len_o, 0);
    check_val("t7_byte_valid", byte_valid_o, 0);
    check_val("t7_byte", byte_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
